idelay_tap_ctrl: RTL and testbench

- Upstream control stage for the cascaded IDELAYE3 delay-line model. Drives its CE / INC / RST / EN_VTC pins.
- Accepts "move to tap N" or "reset delay" commands over a valid/ready handshake.
- Walks the delay select one tap per step, with a programmable settle gap between steps, and tracks the current tap.
- Sits between the calibration/training logic and the delay line (NMBR_CASCADES taps; in BALANCED mode tap 0 = select 00000001).

---
 rtl/idelay_ctrl_pkg.sv | 8 +
 rtl/idelay_tap_ctrl_if.sv | 9 +
 rtl/idelay_step_timer.sv | 18 +
 rtl/idelay_tap_ctrl.sv | 120 ++++++++++++
 tb/tb_idelay_tap_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/idelay_ctrl_pkg.sv
// idelay_ctrl_pkg: shared state type, constants and width helper for the IDELAY tap controller
package idelay_ctrl_pkg;
  typedef enum logic [2:0] {INIT, IDLE, DRST, STEP, SETTLE, FIN} state_t;
  localparam int DRST_CYCLES = 2;
  function automatic int tap_width(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/idelay_tap_ctrl_if.sv
// idelay_tap_ctrl_if: command handshake (valid/ready, reset request, target tap) into the tap controller
interface idelay_tap_ctrl_if #(parameter int TAP_W = 4);
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_rst;
  logic [TAP_W-1:0] cmd_tap;
  modport master (output cmd_valid, cmd_rst, cmd_tap, input cmd_ready);
  modport slave (input cmd_valid, cmd_rst, cmd_tap, output cmd_ready);
endinterface

// File: rtl/idelay_step_timer.sv
// idelay_step_timer: settle down-counter, loaded on each CE step, expired once the gap has elapsed
module idelay_step_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= CW'(SETTLE_CYCLES - 1);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/idelay_tap_ctrl.sv
// idelay_tap_ctrl: walks an IDELAY line one tap per step with settle gaps; IDELAY_STEP_CNT_EN adds step_cnt/step_cnt_clr
module idelay_tap_ctrl
  import idelay_ctrl_pkg::*;
#(
  parameter int NMBR_CASCADES = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int TAP_W = tap_width(NMBR_CASCADES)
) (
  input  logic             CLK,
  input  logic             RST,
  idelay_tap_ctrl_if.slave cmd,
`ifdef IDELAY_STEP_CNT_EN
  input  logic             step_cnt_clr,
  output logic [15:0]      step_cnt,
`endif
  output logic             dly_ce,
  output logic             dly_inc,
  output logic             dly_rst,
  output logic             dly_en_vtc,
  output logic [TAP_W-1:0] cur_tap,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam logic [TAP_W-1:0] TAP_LIMIT = TAP_W'(NMBR_CASCADES);
  localparam logic [1:0] DRST_LAST = 2'(DRST_CYCLES - 1);
  state_t state;
  logic [TAP_W-1:0] target;
  logic [1:0] drst_cnt;
  logic from_init;
  logic settle_done;
  idelay_step_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk(CLK),
    .rst(RST),
    .load(state == STEP),
    .expired(settle_done)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
      cur_tap <= '0;
      target <= '0;
      drst_cnt <= '0;
      from_init <= 1'b0;
      dly_ce <= 1'b0;
      dly_inc <= 1'b0;
      dly_rst <= 1'b0;
      dly_en_vtc <= 1'b0;
      cmd.cmd_ready <= 1'b0;
      busy <= 1'b1;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      dly_ce <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        INIT: begin
          state <= DRST;
          from_init <= 1'b1;
          drst_cnt <= '0;
          dly_rst <= 1'b1;
        end
        IDLE: if (cmd.cmd_valid) begin
          cmd.cmd_ready <= 1'b0;
          busy <= 1'b1;
          dly_en_vtc <= 1'b0;
          if (cmd.cmd_rst) begin
            state <= DRST;
            from_init <= 1'b0;
            drst_cnt <= '0;
            dly_rst <= 1'b1;
          end else if (cmd.cmd_tap >= TAP_LIMIT || cmd.cmd_tap == cur_tap) begin
            state <= FIN;
            done <= 1'b1;
            err <= cmd.cmd_tap >= TAP_LIMIT;
          end else begin
            state <= STEP;
            target <= cmd.cmd_tap;
            dly_ce <= 1'b1;
            dly_inc <= cmd.cmd_tap > cur_tap;
          end
        end
        DRST: if (drst_cnt == DRST_LAST) begin
          dly_rst <= 1'b0;
          cur_tap <= '0;
          state <= from_init ? IDLE : FIN;
          done <= !from_init;
          cmd.cmd_ready <= from_init;
          busy <= !from_init;
          dly_en_vtc <= from_init;
        end else begin
          drst_cnt <= drst_cnt + 1'b1;
        end
        STEP: begin
          state <= SETTLE;
          cur_tap <= dly_inc ? cur_tap + 1'b1 : cur_tap - 1'b1;
        end
        SETTLE: if (settle_done) begin
          state <= cur_tap == target ? FIN : STEP;
          done <= cur_tap == target;
          dly_ce <= cur_tap != target;
        end
        FIN: begin
          state <= IDLE;
          cmd.cmd_ready <= 1'b1;
          busy <= 1'b0;
          dly_en_vtc <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end
`ifdef IDELAY_STEP_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST || step_cnt_clr) step_cnt <= '0;
    else if (dly_ce && step_cnt != 16'hFFFF) step_cnt <= step_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_idelay_tap_ctrl.sv
// tb_idelay_tap_ctrl: directed and random tap commands checked against a latency/position model
module tb_idelay_tap_ctrl;
  import idelay_ctrl_pkg::*;
  localparam int N = 8;
  localparam int S = 4;
  localparam int TW = tap_width(N);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dly_ce, dly_inc, dly_rst, dly_en_vtc, busy, done, err;
  logic [TW-1:0] cur_tap;
  int errors = 0;
  int checks = 0;
  int model_tap = 0;
  idelay_tap_ctrl_if #(.TAP_W(TW)) bus ();
`ifdef IDELAY_STEP_CNT_EN
  logic step_cnt_clr = 1'b0;
  logic [15:0] step_cnt;
`endif
  idelay_tap_ctrl #(.NMBR_CASCADES(N), .SETTLE_CYCLES(S), .TAP_W(TW)) dut (
    .CLK(clk),
    .RST(rst),
    .cmd(bus.slave),
`ifdef IDELAY_STEP_CNT_EN
    .step_cnt_clr(step_cnt_clr),
    .step_cnt(step_cnt),
`endif
    .dly_ce(dly_ce),
    .dly_inc(dly_inc),
    .dly_rst(dly_rst),
    .dly_en_vtc(dly_en_vtc),
    .cur_tap(cur_tap),
    .busy(busy),
    .done(done),
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk(tag, {dly_ce, dly_inc, dly_rst, dly_en_vtc, bus.cmd_ready, busy, done, err, cur_tap},
        {8'b0000_0100, TW'(0)});
  endtask
  task automatic release_rst();
    int rst_n = 0;
    int done_n = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      rst_n += int'(dly_rst);
      done_n += int'(done);
    end
    chk("init_drst_len", rst_n, 2);
    chk("init_no_done", done_n, 0);
    chk("init_ready", bus.cmd_ready, 1);
    chk("init_busy", busy, 0);
    chk("init_tap", cur_tap, 0);
    chk("init_en_vtc", dly_en_vtc, 1);
    model_tap = 0;
  endtask
  task automatic run_cmd(input bit r, input int tap);
    int k, exp_done, exp_ce, exp_rst, new_tap;
    int c = 1, ce_n = 0, rst_n = 0, vtc_n = 0, bad_inc = 0, bad_gap = 0, last_ce = -100, done_c = 0;
    bit exp_err = 1'b0, exp_inc = 1'b0, err_seen = 1'b0;
    new_tap = model_tap;
    exp_rst = 0;
    exp_ce = 0;
    if (r) begin
      exp_done = 3;
      exp_rst = 2;
      new_tap = 0;
    end else if (tap >= N) begin
      exp_done = 1;
      exp_err = 1'b1;
    end else begin
      k = tap > model_tap ? tap - model_tap : model_tap - tap;
      exp_done = 1 + k * (1 + S);
      exp_ce = k;
      exp_inc = tap > model_tap;
      new_tap = tap;
    end
    @(negedge clk);
    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rst = r;
    bus.cmd_tap = TW'(tap);
    @(posedge clk);
    #1;
    while (done_c == 0 && c <= 200) begin
      if (dly_ce) begin
        ce_n++;
        if (dly_inc !== exp_inc) bad_inc++;
        if (ce_n > 1 && c - last_ce != 1 + S) bad_gap++;
        last_ce = c;
      end
      rst_n += int'(dly_rst);
      vtc_n += int'(dly_en_vtc);
      if (done) begin
        done_c = c;
        err_seen = err;
        bus.cmd_valid = 1'b0;
      end else begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_rst = 1'($urandom_range(0, 1));
        bus.cmd_tap = TW'($urandom);
        @(posedge clk);
        #1;
        c++;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("done_latency", done_c, exp_done);
    chk("ce_count", ce_n, exp_ce);
    chk("inc_dir", bad_inc, 0);
    chk("ce_gap", bad_gap, 0);
    chk("drst_len", rst_n, exp_rst);
    chk("err_flag", err_seen, exp_err);
    chk("tap_at_done", cur_tap, new_tap);
    chk("vtc_off_busy", vtc_n, 0);
    model_tap = new_tap;
    @(posedge clk);
    #1;
    chk("done_one_cycle", {done, err}, 0);
    chk("ready_after", bus.cmd_ready, 1);
  endtask
  initial begin
    int c, n;
    bus.cmd_valid = 1'b0;
    bus.cmd_rst = 1'b0;
    bus.cmd_tap = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_state");
    release_rst();
    run_cmd(1'b0, 5);
    run_cmd(1'b0, 2);
    run_cmd(1'b0, 2);
    run_cmd(1'b0, 9);
    run_cmd(1'b1, 0);
    run_cmd(1'b0, N - 1);
    run_cmd(1'b0, N);
    repeat (12) run_cmd($urandom_range(0, 5) == 0, $urandom_range(0, 2 * N - 1));
    run_cmd(1'b1, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rst = 1'b0;
    bus.cmd_tap = TW'(7);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    c = 0;
    while (n < 3 && c < 100) begin
      if (dly_ce) n++;
      if (n < 3) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    chk("abort_third_ce", n, 3);
    repeat (S) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("abort_reset_state");
    @(posedge clk);
    #1;
    chk_reset("abort_reset_hold");
    release_rst();
`ifdef IDELAY_STEP_CNT_EN
    @(negedge clk);
    step_cnt_clr = 1'b1;
    @(negedge clk);
    step_cnt_clr = 1'b0;
    run_cmd(1'b0, 7);
    run_cmd(1'b0, 0);
    chk("step_cnt_sweep", step_cnt, 14);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rst = 1'b0;
    bus.cmd_tap = TW'(2);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    chk("ce_for_clr", dly_ce, 1);
    step_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    step_cnt_clr = 1'b0;
    chk("step_cnt_clr_wins", step_cnt, 0);
    c = 0;
    while (!done && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("step_cnt_after_clr", step_cnt, 1);
    model_tap = 2;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
